// File: rtl/w0rm_bus_pkg.sv
// Shared definitions for the w0rm data bus arbiter: FSM encoding and timeout counter width.
package w0rm_bus_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/w0rm_rr_pick.sv
// Round-robin picker: first requester at or above rr_ptr, wrapping to master 0.
module w0rm_rr_pick #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

  int unsigned      sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      sum  = 32'(rr_ptr) + k;
      cand = IDX_W'(sum % NUM_MASTERS);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w0rm_data_bus_arbiter.sv
// Round-robin arbiter sharing the core data bus; one transaction outstanding,
// each winner gets its bus response or a timeout error back.
module w0rm_data_bus_arbiter
  import w0rm_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_accept,
  output logic [NUM_MASTERS-1:0]            m_resp_valid,
  output logic                              m_resp_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              data_bus_write_out,
  output logic                              data_bus_read_out,
  output logic                              data_bus_valid_out,
  output logic [ADDR_WIDTH-1:0]             data_bus_addr_out,
  output logic [DATA_WIDTH-1:0]             data_bus_data_out,
  input  logic [DATA_WIDTH-1:0]             data_bus_data_in,
  input  logic                              data_bus_valid_in,
  output logic                              busy
);

  localparam int unsigned      IDX_W    = $clog2(NUM_MASTERS);
  localparam int unsigned      AW       = ADDR_WIDTH;
  localparam int unsigned      DW       = DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  logic [ST_W-1:0]        state_q, state_n;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_n;
  logic [IDX_W-1:0]       winner_q, winner_n;
  logic                   is_write_q, is_write_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;

  logic [NUM_MASTERS-1:0] accept_n, resp_valid_n;
  logic                   resp_err_n, bus_write_n, bus_read_n, bus_valid_n, busy_n;
  logic [DW-1:0]          rdata_n, bus_data_n;
  logic [AW-1:0]          bus_addr_n;

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       pick;
  logic                   any_req;
  logic [AW-1:0]          pick_addr;
  logic [DW-1:0]          pick_wdata;

  assign req = m_write | m_read;

  w0rm_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .winner  (pick),
    .any_req (any_req)
  );

  // Unpack the candidate winner's address and write data
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_addr  = m_addr[i*AW +: AW];
        pick_wdata = m_wdata[i*DW +: DW];
      end
    end
  end

  // Outputs are computed one state ahead so they are registered yet land in their own state
  always_comb begin
    state_n      = state_q;
    rr_ptr_n     = rr_ptr_q;
    winner_n     = winner_q;
    is_write_n   = is_write_q;
    cnt_n        = cnt_q;
    accept_n     = '0;
    resp_valid_n = '0;
    resp_err_n   = 1'b0;
    rdata_n      = '0;
    bus_write_n  = 1'b0;
    bus_read_n   = 1'b0;
    bus_valid_n  = 1'b0;
    bus_addr_n   = data_bus_addr_out;
    bus_data_n   = data_bus_data_out;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_n        = ST_ISSUE;
          winner_n       = pick;
          is_write_n     = m_write[pick];
          bus_valid_n    = 1'b1;
          bus_write_n    = m_write[pick];
          bus_read_n     = ~m_write[pick];
          bus_addr_n     = pick_addr;
          bus_data_n     = pick_wdata;
          accept_n[pick] = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_n  = ST_WAIT;
        cnt_n    = '0;
        rr_ptr_n = (winner_q == IDX_LAST) ? '0 : winner_q + IDX_W'(1);
      end
      ST_WAIT: begin
        if (data_bus_valid_in) begin
          state_n                = ST_RESP;
          resp_valid_n[winner_q] = 1'b1;
          rdata_n                = is_write_q ? '0 : data_bus_data_in;
        end else if (cnt_q == CNT_LAST) begin
          state_n                = ST_RESP;
          resp_valid_n[winner_q] = 1'b1;
          resp_err_n             = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      rr_ptr_q           <= '0;
      winner_q           <= '0;
      is_write_q         <= 1'b0;
      cnt_q              <= '0;
      m_accept           <= '0;
      m_resp_valid       <= '0;
      m_resp_err         <= 1'b0;
      m_rdata            <= '0;
      data_bus_write_out <= 1'b0;
      data_bus_read_out  <= 1'b0;
      data_bus_valid_out <= 1'b0;
      data_bus_addr_out  <= '0;
      data_bus_data_out  <= '0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_n;
      rr_ptr_q           <= rr_ptr_n;
      winner_q           <= winner_n;
      is_write_q         <= is_write_n;
      cnt_q              <= cnt_n;
      m_accept           <= accept_n;
      m_resp_valid       <= resp_valid_n;
      m_resp_err         <= resp_err_n;
      m_rdata            <= rdata_n;
      data_bus_write_out <= bus_write_n;
      data_bus_read_out  <= bus_read_n;
      data_bus_valid_out <= bus_valid_n;
      data_bus_addr_out  <= bus_addr_n;
      data_bus_data_out  <= bus_data_n;
      busy               <= busy_n;
    end
  end

endmodule

// File: tb/tb_w0rm_data_bus_arbiter.sv
// Directed bench for w0rm_data_bus_arbiter: transaction table plus hand-written
// timeout, stray-ack and async-reset sequences. Inputs driven and outputs sampled on negedge.
module tb_w0rm_data_bus_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NM-1:0]    m_write, m_read, m_accept, m_resp_valid;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic             m_resp_err;
  logic [DW-1:0]    m_rdata;
  logic             data_bus_write_out, data_bus_read_out, data_bus_valid_out;
  logic [AW-1:0]    data_bus_addr_out;
  logic [DW-1:0]    data_bus_data_out, data_bus_data_in;
  logic             data_bus_valid_in, busy;

  always #5 clk = ~clk;

  w0rm_data_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .m_write            (m_write),
    .m_read             (m_read),
    .m_addr             (m_addr),
    .m_wdata            (m_wdata),
    .m_accept           (m_accept),
    .m_resp_valid       (m_resp_valid),
    .m_resp_err         (m_resp_err),
    .m_rdata            (m_rdata),
    .data_bus_write_out (data_bus_write_out),
    .data_bus_read_out  (data_bus_read_out),
    .data_bus_valid_out (data_bus_valid_out),
    .data_bus_addr_out  (data_bus_addr_out),
    .data_bus_data_out  (data_bus_data_out),
    .data_bus_data_in   (data_bus_data_in),
    .data_bus_valid_in  (data_bus_valid_in),
    .busy               (busy)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [31:0] a0, a1, d0, d1;
    int          delay;
    logic [31:0] ack_data;
    int          win;
    logic        is_wr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Caller is at a negedge with the DUT in IDLE
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0]  exp_acc;
    logic [31:0] exp_addr, exp_data;
    exp_acc  = 2'b01 << v.win;
    exp_addr = (v.win == 1) ? v.a1 : v.a0;
    exp_data = (v.win == 1) ? v.d1 : v.d0;
    m_write  = v.wr;
    m_read   = v.rd;
    m_addr   = {v.a1, v.a0};
    m_wdata  = {v.d1, v.d0};
    @(negedge clk);
    chk($sformatf("v%0d_accept", idx), 64'(m_accept), 64'(exp_acc));
    chk($sformatf("v%0d_bus_valid", idx), 64'(data_bus_valid_out), 64'd1);
    chk($sformatf("v%0d_bus_wr_rd", idx), {62'd0, data_bus_write_out, data_bus_read_out},
        {62'd0, v.is_wr, ~v.is_wr});
    chk($sformatf("v%0d_bus_addr", idx), 64'(data_bus_addr_out), 64'(exp_addr));
    if (v.is_wr) chk($sformatf("v%0d_bus_data", idx), 64'(data_bus_data_out), 64'(exp_data));
    m_write[v.win] = 1'b0;
    m_read[v.win]  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < v.delay; i++) begin
      chk($sformatf("v%0d_wait_quiet", idx),
          {59'd0, data_bus_valid_out, m_accept, m_resp_valid}, 64'd0);
      @(negedge clk);
    end
    data_bus_valid_in = 1'b1;
    data_bus_data_in  = v.ack_data;
    @(negedge clk);
    data_bus_valid_in = 1'b0;
    data_bus_data_in  = '0;
    chk($sformatf("v%0d_resp_valid", idx), 64'(m_resp_valid), 64'(exp_acc));
    chk($sformatf("v%0d_resp_err", idx), 64'(m_resp_err), 64'd0);
    chk($sformatf("v%0d_rdata", idx), 64'(m_rdata), 64'(v.rdata));
    chk($sformatf("v%0d_busy_resp", idx), 64'(busy), 64'd1);
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", idx), {61'd0, m_resp_valid, busy}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{wr:2'b00, rd:2'b01, a0:32'h100, a1:32'h0,  d0:32'h0, d1:32'h0, delay:2,
                ack_data:32'hDEADBEEF, win:0, is_wr:1'b0, rdata:32'hDEADBEEF};
    vecs[1] = '{wr:2'b11, rd:2'b00, a0:32'h10,  a1:32'h14, d0:32'hA, d1:32'hB, delay:0,
                ack_data:32'h1234, win:1, is_wr:1'b1, rdata:32'h0};
    vecs[2] = '{wr:2'b11, rd:2'b00, a0:32'h18,  a1:32'h1C, d0:32'hC, d1:32'hD, delay:1,
                ack_data:32'h5555, win:0, is_wr:1'b1, rdata:32'h0};
    vecs[3] = '{wr:2'b11, rd:2'b00, a0:32'h28,  a1:32'h2C, d0:32'hE, d1:32'hF, delay:0,
                ack_data:32'h6666, win:1, is_wr:1'b1, rdata:32'h0};
    vecs[4] = '{wr:2'b10, rd:2'b10, a0:32'h0,   a1:32'h20, d0:32'h0, d1:32'h5, delay:3,
                ack_data:32'h7777, win:1, is_wr:1'b1, rdata:32'h0};
    vecs[5] = '{wr:2'b00, rd:2'b10, a0:32'h0,   a1:32'h200, d0:32'h0, d1:32'h0, delay:0,
                ack_data:32'hCAFEF00D, win:1, is_wr:1'b0, rdata:32'hCAFEF00D};
    vecs[6] = '{wr:2'b00, rd:2'b01, a0:32'h300, a1:32'h0,  d0:32'h0, d1:32'h0, delay:1,
                ack_data:32'h0BADF00D, win:0, is_wr:1'b0, rdata:32'h0BADF00D};

    m_write = '0; m_read = '0; m_addr = '0; m_wdata = '0;
    data_bus_data_in = '0; data_bus_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {55'd0, m_accept, m_resp_valid, m_resp_err, busy,
        data_bus_write_out, data_bus_read_out, data_bus_valid_out}, 64'd0);
    chk("rst_addr", 64'(data_bus_addr_out), 64'd0);
    chk("rst_rdata", {data_bus_data_out, m_rdata}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Timeout: m0 read, no ack for TO wait cycles; rr_ptr=1 here so m0 wins by wrap
    m_read = 2'b01; m_addr = {32'h0, 32'h40};
    data_bus_data_in = 32'hFFFFFFFF;
    @(negedge clk);
    chk("to_accept", 64'(m_accept), 64'h1);
    m_read = '0;
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", i), {62'd0, m_resp_valid}, 64'd0);
    end
    @(negedge clk);
    chk("to_resp_valid", 64'(m_resp_valid), 64'h1);
    chk("to_resp_err", 64'(m_resp_err), 64'd1);
    chk("to_rdata", 64'(m_rdata), 64'd0);
    data_bus_valid_in = 1'b1;
    @(negedge clk);
    chk("late_ack_idle", {60'd0, m_resp_valid, m_resp_err, busy}, 64'd0);
    @(negedge clk);
    chk("late_ack_idle2", {61'd0, busy, data_bus_valid_out, m_resp_err}, 64'd0);

    // Stray ack held through IDLE and ISSUE; m1 write then acked properly
    data_bus_data_in = 32'h99;
    m_write = 2'b10; m_addr = {32'h30, 32'h0}; m_wdata = {32'h77, 32'h0};
    @(negedge clk);
    chk("stray_issue_accept", 64'(m_accept), 64'h2);
    chk("stray_issue_wr", {62'd0, data_bus_write_out, data_bus_read_out}, 64'h2);
    chk("stray_issue_data", 64'(data_bus_data_out), 64'h77);
    m_write = '0;
    data_bus_valid_in = 1'b0;
    @(negedge clk);
    chk("stray_wait", {61'd0, m_resp_valid, busy}, 64'h1);
    data_bus_valid_in = 1'b1;
    @(negedge clk);
    data_bus_valid_in = 1'b0;
    chk("stray_resp_valid", 64'(m_resp_valid), 64'h2);
    chk("stray_resp_rdata", {31'd0, m_resp_err, m_rdata}, 64'd0);
    @(negedge clk);
    chk("stray_idle_after", {61'd0, m_resp_valid, busy}, 64'd0);

    // Async reset during WAIT, then rr_ptr must be back at master 0
    m_read = 2'b01; m_addr = {32'h0, 32'h44};
    @(negedge clk);
    chk("rw_accept", 64'(m_accept), 64'h1);
    m_read = '0;
    @(negedge clk);
    chk("rw_busy_wait", {31'd0, busy, data_bus_addr_out}, {31'd0, 1'b1, 32'h44});
    #2 reset_n = 1'b0;
    #1;
    chk("rw_async_ctrl", {55'd0, m_accept, m_resp_valid, m_resp_err, busy,
        data_bus_write_out, data_bus_read_out, data_bus_valid_out}, 64'd0);
    chk("rw_async_addr", 64'(data_bus_addr_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rw_no_resp", {62'd0, m_resp_valid}, 64'd0);
    reset_n = 1'b1;
    m_write = 2'b11; m_addr = {32'h54, 32'h50}; m_wdata = {32'h2, 32'h1};
    @(negedge clk);
    chk("rw_after_accept", 64'(m_accept), 64'h1);
    chk("rw_after_addr", 64'(data_bus_addr_out), 64'h50);
    m_write = '0;
    @(negedge clk);
    data_bus_valid_in = 1'b1; data_bus_data_in = 32'hABCD;
    @(negedge clk);
    data_bus_valid_in = 1'b0;
    chk("rw_after_resp", 64'(m_resp_valid), 64'h1);
    chk("rw_after_rdata", {31'd0, m_resp_err, m_rdata}, 64'd0);
    @(negedge clk);
    chk("rw_after_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
